// File: rtl/crc32_gen_check_if.sv
// Host-side bundle for the CRC-32 generator/checker: message, polynomial,
// start requests and both engines' results.
interface crc32_gen_check_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data;
  logic [32:0]      polynom_i;
  logic             rd;
  logic             rd_pro;
  logic [31:0]      CRC;
  logic [31:0]      CRC_pro;
  logic             OK;
  logic             out_ready_CRC;
  logic             out_ready_PRO;

  modport master (
    output data, polynom_i, rd, rd_pro,
    input  CRC, CRC_pro, OK, out_ready_CRC, out_ready_PRO
  );

  modport slave (
    input  data, polynom_i, rd, rd_pro,
    output CRC, CRC_pro, OK, out_ready_CRC, out_ready_PRO
  );
endinterface

// File: rtl/crc32_gen_check_top.sv
// CRC-32 generator and checker built from two bit-serial polynomial dividers
// (init 0, no reflection, no final XOR) that run independently on latched operands.

module crc32_serial_engine #(
  parameter int LEN   = 32,
  parameter int CNT_W = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] msg,
  input  logic [31:0]    poly,
  output logic           busy,
  output logic           done,
  output logic [31:0]    rem
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_reg, state_next;
  logic [LEN-1:0]   msg_reg;
  logic [31:0]      poly_reg;
  logic [31:0]      r_reg;
  logic [31:0]      r_step;
  logic [CNT_W-1:0] cnt_reg;
  logic             fb;
  logic             last_shift;

  // msg_reg shifts left so the bit being consumed is always its MSB.
  assign fb         = r_reg[31] ^ msg_reg[LEN-1];
  assign r_step     = {r_reg[30:0], 1'b0} ^ (fb ? poly_reg : 32'h0);
  assign last_shift = (cnt_reg == CNT_W'(LEN - 1));
  assign busy       = (state_reg == S_RUN);
  assign rem        = r_step;

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN: begin
        if (last_shift) begin
          state_next = S_IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_reg  <= '0;
      poly_reg <= '0;
      r_reg    <= '0;
      cnt_reg  <= '0;
    end else if (state_reg == S_IDLE) begin
      if (start) begin
        msg_reg  <= msg;
        poly_reg <= poly;
        r_reg    <= '0;
        cnt_reg  <= '0;
      end
    end else begin
      msg_reg <= msg_reg << 1;
      r_reg   <= r_step;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
endmodule

module crc32_gen_check_top #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  crc32_gen_check_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 33);

  logic             rd_prev_reg;
  logic             rd_pro_prev_reg;
  logic             gen_busy, gen_done, gen_start;
  logic             chk_busy, chk_done, chk_start;
  logic [31:0]      gen_rem, chk_rem;
  logic [31:0]      crc_reg;
  logic [31:0]      crc_pro_reg;
  logic             ok_reg;
  logic             ready_crc_reg;
  logic             ready_pro_reg;
  logic             unused_poly_msb;

  // The x^32 term is implicit in the shift structure.
  assign unused_poly_msb = bus.polynom_i[32];

  assign gen_start = bus.rd     & ~rd_prev_reg     & ~gen_busy;
  assign chk_start = bus.rd_pro & ~rd_pro_prev_reg & ~chk_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_prev_reg     <= 1'b0;
      rd_pro_prev_reg <= 1'b0;
    end else begin
      rd_prev_reg     <= bus.rd;
      rd_pro_prev_reg <= bus.rd_pro;
    end
  end

  crc32_serial_engine #(.LEN(WIDTH), .CNT_W(CNT_W)) u_gen (
    .clk   (clk),
    .rst   (rst),
    .start (gen_start),
    .msg   (bus.data),
    .poly  (bus.polynom_i[31:0]),
    .busy  (gen_busy),
    .done  (gen_done),
    .rem   (gen_rem)
  );

  // The checker latches whatever CRC is registered now, even if a new
  // generation is in flight.
  crc32_serial_engine #(.LEN(WIDTH + 32), .CNT_W(CNT_W)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .start (chk_start),
    .msg   ({bus.data, crc_reg}),
    .poly  (bus.polynom_i[31:0]),
    .busy  (chk_busy),
    .done  (chk_done),
    .rem   (chk_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_reg       <= '0;
      ready_crc_reg <= 1'b0;
    end else if (gen_start) begin
      ready_crc_reg <= 1'b0;
    end else if (gen_done) begin
      crc_reg       <= gen_rem;
      ready_crc_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_pro_reg   <= '0;
      ok_reg        <= 1'b0;
      ready_pro_reg <= 1'b0;
    end else if (chk_start) begin
      crc_pro_reg   <= '0;
      ok_reg        <= 1'b0;
      ready_pro_reg <= 1'b0;
    end else if (chk_done) begin
      crc_pro_reg   <= chk_rem;
      ok_reg        <= (chk_rem == 32'h0);
      ready_pro_reg <= 1'b1;
    end
  end

  assign bus.CRC           = crc_reg;
  assign bus.CRC_pro       = crc_pro_reg;
  assign bus.OK            = ok_reg;
  assign bus.out_ready_CRC = ready_crc_reg;
  assign bus.out_ready_PRO = ready_pro_reg;
endmodule

// File: tb/tb_crc32_gen_check_top.sv
// Self-checking bench for crc32_gen_check_top: table vectors, random operands
// against a polynomial long-division model, and reset/hold/overlap sequences.
module tb_crc32_gen_check_top;
  localparam int WIDTH = 32;
  localparam logic [32:0] P_ETH = 33'h1_04C11DB7;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  crc32_gen_check_if #(.WIDTH(WIDTH)) bus ();

  crc32_gen_check_top #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [32:0] poly;
    logic [31:0] exp_crc;
  } vec_t;

  vec_t vecs[6];

  // Remainder of v(x) modulo p(x) over GF(2), by plain long division.
  function automatic logic [31:0] mod_p(input logic [95:0] v, input logic [32:0] p);
    logic [95:0] r;
    r = v;
    for (int i = 95; i >= 32; i--)
      if (r[i]) r[i-:33] = r[i-:33] ^ p;
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_crc(input logic [31:0] d, input logic [32:0] p);
    return mod_p({32'h0, d, 32'h0}, p);
  endfunction

  function automatic logic [31:0] ref_chk(input logic [31:0] d, input logic [31:0] c,
                                          input logic [32:0] p);
    return mod_p({d, c, 32'h0}, p);
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse one start request and return the cycle count until its ready flag
  // (counted from the negedge after the start edge), or -1 on timeout.
  task automatic run_op(input bit is_chk, output int lat);
    lat = -1;
    @(negedge clk);
    if (is_chk) bus.rd_pro = 1'b1; else bus.rd = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.rd = 1'b0;
        bus.rd_pro = 1'b0;
      end
      if (is_chk ? bus.out_ready_PRO : bus.out_ready_CRC) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic gen_and_check(input logic [31:0] d, input logic [32:0] p,
                               input logic [31:0] exp, input string tag);
    int lat;
    bus.data = d;
    bus.polynom_i = p;
    run_op(1'b0, lat);
    $display("gen %s data=%h poly=%h crc=%h lat=%0d", tag, d, p, bus.CRC, lat);
    check({tag, "_gen_lat"}, 96'(lat), 96'(WIDTH + 1));
    check({tag, "_crc"}, 96'(bus.CRC), 96'(exp));
  endtask

  task automatic chk_and_check(input logic [31:0] d, input logic [31:0] model_crc,
                               input logic [32:0] p, input string tag);
    int lat;
    logic [31:0] exp_rem;
    exp_rem = ref_chk(d, model_crc, p);
    bus.data = d;
    bus.polynom_i = p;
    run_op(1'b1, lat);
    $display("chk %s data=%h rem=%h ok=%0b lat=%0d", tag, d, bus.CRC_pro, bus.OK, lat);
    check({tag, "_chk_lat"}, 96'(lat), 96'(WIDTH + 33));
    check({tag, "_rem"}, 96'(bus.CRC_pro), 96'(exp_rem));
    check({tag, "_ok"}, 96'(bus.OK), 96'(exp_rem == 32'h0));
  endtask

  function automatic logic [95:0] all_outs();
    return {bus.CRC, bus.CRC_pro, bus.OK, bus.out_ready_CRC, bus.out_ready_PRO};
  endfunction

  initial begin
    int lat, pulses, ready_hits, g_lat, c_lat;
    logic prev;
    logic [31:0] d, c, old_crc;
    logic [32:0] p;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.data = '0;
    bus.polynom_i = P_ETH;
    bus.rd = 1'b0;
    bus.rd_pro = 1'b0;

    // Reset with requests toggling: nothing may start.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.rd = ~bus.rd;
      bus.rd_pro = ~bus.rd_pro;
    end
    @(negedge clk);
    check("reset_outs", all_outs(), 96'h0);
    bus.rd = 1'b0;
    bus.rd_pro = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_outs", all_outs(), 96'h0);

    vecs[0] = '{32'h00000001, P_ETH, 32'h04C11DB7};
    vecs[1] = '{32'h00000002, P_ETH, 32'h09823B6E};
    vecs[2] = '{32'h00000000, P_ETH, 32'h00000000};
    vecs[3] = '{32'h00000001, 33'h1_814141AB, 32'h814141AB};
    vecs[4] = '{32'h566F8B44, P_ETH, ref_crc(32'h566F8B44, P_ETH)};
    vecs[5] = '{32'h80000000, P_ETH, ref_crc(32'h80000000, P_ETH)};
    for (int i = 0; i < 6; i++) begin
      gen_and_check(vecs[i].data, vecs[i].poly, vecs[i].exp_crc, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_ready", i), 96'(bus.out_ready_CRC), 96'h1);
      chk_and_check(vecs[i].data, vecs[i].exp_crc, vecs[i].poly, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_ok_const", i), 96'(bus.OK), 96'h1);
    end

    // Corrupted data after generation must fail the check.
    gen_and_check(32'h00000001, P_ETH, 32'h04C11DB7, "corrupt");
    chk_and_check(32'h00000003, 32'h04C11DB7, P_ETH, "corrupt");
    check("corrupt_ok_low", 96'(bus.OK), 96'h0);

    // Random operands against the long-division model.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      p = {1'b1, 32'($urandom)};
      c = ref_crc(d, p);
      gen_and_check(d, p, c, $sformatf("rnd%0d", i));
      if (i % 2 == 1) d = d ^ (32'h1 << $urandom_range(31, 0));
      chk_and_check(d, c, p, $sformatf("rnd%0d", i));
    end

    // Simultaneous starts: checker sees the previous CRC; a busy rd edge is ignored.
    old_crc = bus.CRC;
    d = 32'hCAFE0123;
    bus.data = d;
    bus.polynom_i = P_ETH;
    g_lat = -1;
    c_lat = -1;
    @(negedge clk);
    bus.rd = 1'b1;
    bus.rd_pro = 1'b1;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      bus.rd = (n == 5);
      bus.rd_pro = 1'b0;
      if (n == 2) bus.data = $urandom;
      if (bus.out_ready_CRC && g_lat < 0) g_lat = n;
      if (bus.out_ready_PRO && c_lat < 0) c_lat = n;
      if (g_lat >= 0 && c_lat >= 0) break;
    end
    bus.rd = 1'b0;
    $display("overlap crc=%h rem=%h glat=%0d clat=%0d", bus.CRC, bus.CRC_pro, g_lat, c_lat);
    check("overlap_gen_lat", 96'(g_lat), 96'(WIDTH + 1));
    check("overlap_chk_lat", 96'(c_lat), 96'(WIDTH + 33));
    check("overlap_crc", 96'(bus.CRC), 96'(ref_crc(d, P_ETH)));
    check("overlap_rem", 96'(bus.CRC_pro), 96'(ref_chk(d, old_crc, P_ETH)));

    // Reset mid-computation aborts without a ready pulse.
    bus.data = 32'h00001234;
    @(negedge clk);
    bus.rd = 1'b1;
    repeat (10) begin
      @(negedge clk);
      bus.rd = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_outs", all_outs(), 96'h0);
    @(negedge clk);
    rst = 1'b0;
    ready_hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_ready_CRC) ready_hits++;
    end
    $display("abort ready_hits=%0d", ready_hits);
    check("abort_no_ready", 96'(ready_hits), 96'h0);

    // rd held high for 100 cycles gives exactly one computation.
    pulses = 0;
    prev = bus.out_ready_CRC;
    @(negedge clk);
    bus.rd = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bus.out_ready_CRC && !prev) pulses++;
      prev = bus.out_ready_CRC;
    end
    bus.rd = 1'b0;
    $display("hold crc=%h pulses=%0d", bus.CRC, pulses);
    check("hold_one_start", 96'(pulses), 96'h1);
    check("hold_crc", 96'(bus.CRC), 96'(ref_crc(32'h00001234, P_ETH)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
